// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC widths, frame length helper and serializer state encoding
package cordic_pkg;

  localparam int MAG_W_DEF   = 16;
  localparam int PHASE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } ser_state_t;

  function automatic int nbytes(input int mag_w, input int phase_w);
    return mag_w / 8 + phase_w / 8;
  endfunction

endpackage

// File: rtl/cordic_result_serializer_if.sv
// rtl/cordic_result_serializer_if.sv - result input port and byte output port of the serializer
interface cordic_result_serializer_if #(
  parameter int MAG_W   = 16,
  parameter int PHASE_W = 32
);
  logic               res_valid;
  logic               res_ready;
  logic [MAG_W-1:0]   res_mag;
  logic [PHASE_W-1:0] res_phase;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;

  modport master (
    output res_valid, res_mag, res_phase, out_ready,
    input  res_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  res_valid, res_mag, res_phase, out_ready,
    output res_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/cordic_result_fifo.sv
// rtl/cordic_result_fifo.sv - parameterised synchronous circular FIFO with full/empty/count
module cordic_result_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on the same edge frees the head slot, so a push at full is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cordic_result_serializer.sv
// rtl/cordic_result_serializer.sv - buffers {mag, phase} results and streams them LSB byte first; CORDIC_SER_CHECKSUM_EN adds an XOR trailer byte
module cordic_result_serializer
  import cordic_pkg::*;
#(
  parameter int MAG_W      = MAG_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  cordic_result_serializer_if.slave bus
);

  localparam int         DW       = MAG_W + PHASE_W;
  localparam int         NBYTES   = nbytes(MAG_W, PHASE_W);
  localparam int         CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);
`ifdef CORDIC_SER_CHECKSUM_EN
  localparam bit LAST_ON_DATA = 1'b0;
`else
  localparam bit LAST_ON_DATA = 1'b1;
`endif

  logic [DW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          hs;
  logic          frame_end;

  ser_state_t    state;
  logic [DW-1:0] shreg;
  logic [7:0]    idx;
  logic [7:0]    out_data_r;
  logic          out_valid_r;
  logic          out_last_r;
`ifdef CORDIC_SER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  assign bus.res_ready = !fifo_full && !rst;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = (fifo_count != '0) || (state != IDLE);

  assign push = bus.res_valid && bus.res_ready;
  assign hs   = out_valid_r && bus.out_ready;

  always_comb begin
    frame_end = 1'b0;
`ifdef CORDIC_SER_CHECKSUM_EN
    frame_end = (state == CHK);
`else
    frame_end = (state == SEND) && (idx == LAST_IDX);
`endif
    // Loading straight from the final handshake avoids an idle bubble between frames.
    pop = !fifo_empty && ((state == IDLE) || (hs && frame_end));
  end

  cordic_result_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.res_phase, bus.res_mag}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
`ifdef CORDIC_SER_CHECKSUM_EN
      chk         <= '0;
`endif
    end else if (pop) begin
      state       <= SEND;
      shreg       <= fifo_dout;
      idx         <= '0;
      out_data_r  <= fifo_dout[7:0];
      out_valid_r <= 1'b1;
      out_last_r  <= 1'b0;
`ifdef CORDIC_SER_CHECKSUM_EN
      chk         <= fifo_dout[7:0];
`endif
    end else if (hs) begin
      case (state)
        SEND: begin
          if (idx == LAST_IDX) begin
`ifdef CORDIC_SER_CHECKSUM_EN
            state       <= CHK;
            out_data_r  <= chk;
            out_last_r  <= 1'b1;
`else
            state       <= IDLE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
`endif
          end else begin
            shreg      <= shreg >> 8;
            idx        <= idx + 8'd1;
            out_data_r <= shreg[15:8];
            out_last_r <= LAST_ON_DATA && (idx == LAST_IDX - 8'd1);
`ifdef CORDIC_SER_CHECKSUM_EN
            chk        <= chk ^ shreg[15:8];
`endif
          end
        end
        CHK: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_data_r  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
